// File: rtl/cordic_rom_pkg.sv
// Shared definitions for the CORDIC coefficient memory: geometry, the bit
// layout of one 48-bit coefficient word, and the loader state encoding.
// The unpack stage imports the same field positions, so the writer and the
// reader always agree on where each coefficient lives in a word.
package cordic_rom_pkg;

    localparam int ADDR_W = 10;    // {index_qua[2:0], index_cor[6:0]}
    localparam int WORD_W = 48;
    localparam int DEPTH  = 1024;

    // Word layout: {XM[15:0], XR[7:0], YM[15:0], YR[7:0]}
    localparam int XM_MSB = 47;
    localparam int XM_LSB = 32;
    localparam int XR_MSB = 31;
    localparam int XR_LSB = 24;
    localparam int YM_MSB = 23;
    localparam int YM_LSB = 8;
    localparam int YR_MSB = 7;
    localparam int YR_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/cordic_rom_writer_pack.sv
// rom_word_pack: combinational packing of one coefficient entry into a
// 48-bit memory word, plus detection of residual bits that do not fit.
// Ports:
//   XM, YM  in  16  main coefficients, stored in full
//   XR, YR  in  16  residual coefficients, only the low byte is stored
//   word    out 48  packed word
//   trunc   out 1   an upper residual byte was nonzero (data is lost)
module rom_word_pack
    import cordic_rom_pkg::*;
(
    input  logic [15:0]       XM,
    input  logic [15:0]       XR,
    input  logic [15:0]       YM,
    input  logic [15:0]       YR,
    output logic [WORD_W-1:0] word,
    output logic              trunc
);

    always_comb begin
        word                 = '0;
        word[XM_MSB:XM_LSB]  = XM;
        word[XR_MSB:XR_LSB]  = XR[7:0];
        word[YM_MSB:YM_LSB]  = YM;
        word[YR_MSB:YR_LSB]  = YR[7:0];
        trunc                = (XR[15:8] != 8'd0) || (YR[15:8] != 8'd0);
    end

endmodule

// File: rtl/cordic_rom_writer.sv
// cordic_rom_writer: loads the CORDIC coefficient memory from a valid/ready
// stream of (XM, YM, XR, YR) entries, writing consecutive addresses from a
// base (modulo 1024), then optionally reads the range back and compares an
// additive checksum of the readback against the checksum of what was written.
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-low reset
//   start                begin a session, only honoured while idle
//   base_addr, count     first address and number of entries (0..1024)
//   in_valid/in_ready    entry handshake; XM/YM/XR/YR carry the entry
//   mem_we/mem_re        memory write / read strobes (never both high)
//   mem_addr, mem_d      memory address and write data
//   mem_q                read data, valid one cycle after mem_re
//   busy, done           session active / one-cycle completion pulse
//   err_trunc            sticky: a residual upper byte was nonzero
//   err_verify           sticky: readback checksum differed
//   err_cfg              sticky: start requested with count > 1024
module cordic_rom_writer
    import cordic_rom_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int WORD_W    = 48,
    parameter bit VERIFY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       XM,
    input  logic [15:0]       YM,
    input  logic [15:0]       XR,
    input  logic [15:0]       YR,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_d,
    input  logic [WORD_W-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic              err_trunc,
    output logic              err_verify,
    output logic              err_cfg
);

    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    r_count;
    logic [WORD_W-1:0]   r_wr_sum;
    logic [WORD_W-1:0]   r_rd_sum;
    logic                r_rd_valid;
    logic                r_err_trunc;
    logic                r_err_verify;
    logic                r_err_cfg;

    logic [WORD_W-1:0]   w_word;
    logic                w_trunc;
    logic                w_hs;
    logic [WORD_W-1:0]   w_rd_sum_next;

    rom_word_pack u_pack (
        .XM    (XM),
        .XR    (XR),
        .YM    (YM),
        .YR    (YR),
        .word  (w_word),
        .trunc (w_trunc)
    );

    // Strobes decode straight from the state register so a reset drops them
    // in the same cycle rather than one clock later.
    assign in_ready   = (r_state == ST_WRITE);
    assign w_hs       = in_ready && in_valid;
    assign mem_we     = w_hs;
    assign mem_re     = (r_state == ST_VERIFY);
    assign mem_addr   = (r_state == ST_VERIFY) ? r_rd_ptr :
                        (r_state == ST_WRITE)  ? r_wr_ptr : '0;
    assign mem_d      = w_hs ? w_word : '0;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign err_trunc  = r_err_trunc;
    assign err_verify = r_err_verify;
    assign err_cfg    = r_err_cfg;

    // Readback sum including the word arriving this cycle; in DRAIN this is
    // the final total, which lets err_verify be valid alongside done.
    assign w_rd_sum_next = r_rd_valid ? (r_rd_sum + mem_q) : r_rd_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_remaining  <= '0;
            r_count      <= '0;
            r_wr_sum     <= '0;
            r_rd_sum     <= '0;
            r_rd_valid   <= 1'b0;
            r_err_trunc  <= 1'b0;
            r_err_verify <= 1'b0;
            r_err_cfg    <= 1'b0;
        end else begin
            // mem_q trails each read strobe by one cycle.
            r_rd_valid <= (r_state == ST_VERIFY);
            r_rd_sum   <= w_rd_sum_next;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (count > MAX_COUNT) begin
                            r_err_cfg <= 1'b1;
                        end else if (count == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_wr_ptr     <= base_addr;
                            r_rd_ptr     <= base_addr;
                            r_remaining  <= count;
                            r_count      <= count;
                            r_wr_sum     <= '0;
                            r_rd_sum     <= '0;
                            r_err_trunc  <= 1'b0;
                            r_err_verify <= 1'b0;
                            r_err_cfg    <= 1'b0;
                            r_state      <= ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    if (w_hs) begin
                        r_wr_sum    <= r_wr_sum + w_word;
                        r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
                        r_remaining <= r_remaining - CNT_ONE;
                        if (w_trunc) begin
                            r_err_trunc <= 1'b1;
                        end
                        if (r_remaining == CNT_ONE) begin
                            if (VERIFY_EN) begin
                                r_remaining <= r_count;
                                r_state     <= ST_VERIFY;
                            end else begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                end

                ST_VERIFY: begin
                    r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
                    r_remaining <= r_remaining - CNT_ONE;
                    if (r_remaining == CNT_ONE) begin
                        r_state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    r_err_verify <= (w_rd_sum_next != r_wr_sum);
                    r_state      <= ST_DONE;
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
